// File: rtl/adiabatic_pclk_gen.sv
// Four-phase trapezoidal power-clock sequencer for dual-rail adiabatic logic.
// Each phase ramps up, holds, ramps down and waits, one quarter behind the
// previous phase. Phases only join at the start of a ramp-up and only leave at
// the start of a wait, so no supply rail ever sees a truncated ramp.
module adiabatic_pclk_gen #(
  parameter int unsigned STEPS = 8,
  parameter int unsigned LW    = $clog2(STEPS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  output logic [4*LW-1:0]   pos_lvl,
  output logic [4*LW-1:0]   neg_lvl,
  output logic [3:0]        phase_active,
  output logic              busy,
  output logic              qtick
);

  localparam int unsigned SW = (STEPS > 1) ? $clog2(STEPS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]      state, state_n;
  logic [SW-1:0]   sub, sub_n, sub_adv;
  logic [1:0]      q, q_n, q_adv;
  logic [3:0]      act_n;
  logic            wrap;
  logic [1:0]      lq;
  logic [LW-1:0]   lvl;
  logic [4*LW-1:0] pos_n, neg_n;
  logic            busy_n, qtick_n;

  // State and quarter counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      sub   <= '0;
      q     <= '0;
    end else begin
      state <= state_n;
      sub   <= sub_n;
      q     <= q_n;
    end
  end

  // Next state, counter advance and phase admission/retirement
  always_comb begin
    state_n = state;
    sub_n   = sub;
    q_n     = q;
    act_n   = phase_active;
    wrap    = (sub == SW'(STEPS - 1));
    sub_adv = wrap ? '0 : sub + SW'(1);
    q_adv   = wrap ? q + 2'd1 : q;
    case (state)
      S_IDLE: begin
        if (start && !stop) begin
          state_n = S_RUN;
          sub_n   = '0;
          q_n     = '0;
          act_n   = 4'b0001;
        end
      end
      S_RUN: begin
        sub_n = sub_adv;
        q_n   = q_adv;
        if (stop) begin
          state_n = S_DRAIN;
        end else begin
          for (int k = 0; k < 4; k++) begin
            if (q_adv == 2'(k) && sub_adv == '0) act_n[k] = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        sub_n = sub_adv;
        q_n   = q_adv;
        for (int k = 0; k < 4; k++) begin
          if (q_adv == 2'(k + 3) && sub_adv == '0) act_n[k] = 1'b0;
        end
        if (act_n == 4'b0000) begin
          state_n = S_IDLE;
          sub_n   = '0;
          q_n     = '0;
        end
      end
      default: begin
        state_n = S_IDLE;
        sub_n   = '0;
        q_n     = '0;
        act_n   = 4'b0000;
      end
    endcase
  end

  // Per-phase charger level for the upcoming cycle (R, H, F, W by local quarter)
  always_comb begin
    pos_n = '0;
    neg_n = '0;
    lq    = '0;
    lvl   = '0;
    for (int k = 0; k < 4; k++) begin
      lvl = '0;
      lq  = q_n - 2'(k);
      if (act_n[k]) begin
        case (lq)
          2'd0:    lvl = LW'(sub_n) + LW'(1);
          2'd1:    lvl = LW'(STEPS);
          2'd2:    lvl = LW'(STEPS - 1) - LW'(sub_n);
          default: lvl = '0;
        endcase
      end
      pos_n[k*LW +: LW] = lvl;
      neg_n[k*LW +: LW] = LW'(STEPS) - lvl;
    end
    busy_n  = (state_n != S_IDLE);
    qtick_n = busy_n && (sub_n == SW'(STEPS - 1));
  end

  // Output registers, loaded with values consistent with the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_lvl      <= '0;
      neg_lvl      <= {4{LW'(STEPS)}};
      phase_active <= '0;
      busy         <= 1'b0;
      qtick        <= 1'b0;
    end else begin
      pos_lvl      <= pos_n;
      neg_lvl      <= neg_n;
      phase_active <= act_n;
      busy         <= busy_n;
      qtick        <= qtick_n;
    end
  end

endmodule

// File: doc/adiabatic_pclk_gen.md
# adiabatic_pclk_gen

Digital sequencer for the four-phase trapezoidal power clocks that drive the dual-rail adiabatic gate library (`clkpos`/`clkneg` supply pins).
- For each phase, it produces a stepwise-charger level code for `clkpos` and a complementary code for `clkneg`.
- Each phase runs a ramp-up, hold, ramp-down, wait sequence, lagging the previous phase by one quarter.
- It starts the phases cleanly on `start` and drains them on `stop`, so no gate sees a truncated ramp.

## Interface
- `STEPS`, default 8: charger steps per quarter. Must be at least 2. Each quarter lasts `STEPS` cycles.
- `LW`, default `$clog2(STEPS+1)`: width of one level code.
- `clk`  input  1: single system clock. All state updates on the rising edge.
- `reset`  input  1: synchronous, active-high reset.
- `start`  input  1: level-sampled request to begin generating.
- `stop`  input  1: level-sampled request to drain and return to idle.
- `pos_lvl`  output  4*LW: `clkpos` level for phase k, at bits `[k*LW +: LW]`.
- `neg_lvl`  output  4*LW: `clkneg` level for phase k. Always equals `STEPS - pos_lvl` for that phase.
- `phase_active`  output  4: bit k is 1 while phase k is being driven.
- `busy`  output  1: state is RUN or DRAIN.
- `qtick`  output  1: marks the last cycle of each quarter while busy.

## Operation
**State machine: IDLE, RUN, DRAIN.**
- Counters are `sub` (0..STEPS-1) and `q` (0..3). `sub` wraps to 0 and `q` increments mod 4.
- Phase k's local quarter is `lq = (q - k) mod 4`. Local quarters map as 0 = R, 1 = H, 2 = F, 3 = W.

**Level of an active phase:**
- R: `sub+1`
- H: `STEPS`
- F: `STEPS-1-sub`
- W: 0
- An inactive phase always outputs `pos = 0` and `neg = STEPS`.

**IDLE**
- `q = sub = 0`, `phase_active = 0`, `busy = 0`.
- `start=1` with `stop=0` → RUN. The first RUN cycle has `q=0`, `sub=0`.
- `start` and `stop` together → stay in IDLE (`stop` has priority).
- `stop` alone is ignored.

**RUN**
- Counters advance every cycle.
- Phase k becomes active in the first cycle with `q==k` and `sub==0`. It enters at the start of its R quarter and never mid-ramp.
- `start` is ignored.
- `stop=1` → DRAIN on the next edge.

**DRAIN**
- Counters keep advancing.
- Inactive phases never activate.
- An active phase stays active through the end of its F quarter. It deactivates on the edge that enters its W quarter (`q == (k+3) mod 4`, `sub == 0`).
- On the edge where the last active phase deactivates, go to IDLE: counters clear, `busy = 0`.
- `start` and `stop` are ignored.

**Other rules**
- `qtick = busy && sub == STEPS-1`.
- One full cycle of each phase is `4*STEPS` clock cycles.

## Timing
- **Reset values:**
  - `pos_lvl = 0`
  - every `neg_lvl` field = `STEPS`
  - `phase_active = 0`
  - `busy = 0`
  - `qtick = 0`
  - state IDLE
- **Reset mid-operation:** takes effect on the next edge and overrides all other inputs. There is no ramp-down, and outputs jump to reset values.
- **Start latency:** with `start` sampled at edge N:
  - `busy = 1` and `phase_active[0] = 1` from cycle N+1;
  - `pos_lvl[0] = 1` in cycle N+1.
  - Phase k first becomes nonzero at cycle N+1+k*STEPS.
- **Stop latency:** the `stop` sample takes effect on the next edge. Drain completes within `4*STEPS` cycles of entering DRAIN.
- **Registered outputs:** all outputs are registered, with no combinational path from inputs to outputs.
- **Level step rule:** no phase level ever changes by more than 1 between consecutive cycles.

## Test plan
(All scenarios use `STEPS=4`.)
- **Reset:** hold `reset` 3 cycles → all `pos` fields 0, all `neg` fields 4, `busy=0`, `phase_active=0`.
- **Start sequence:** `start` pulse at edge 0 →
  - `pos_lvl[0]` over cycles 1..16 reads 1,2,3,4,4,4,4,4,3,2,1,0,0,0,0,0, then repeats.
  - `pos_lvl[1]` is 0 for cycles 1..4, then 1,2,3,4,...
  - `phase_active` reads 0001, 0011, 0111, 1111 at cycles 1, 5, 9, 13.
  - `qtick` is high at cycles 4, 8, 12, 16.
- **Early stop:** `start` at edge 0, `stop` in cycle 1 → phases 1–3 never activate. Phase 0 completes R/H/F, then IDLE. `busy` is high for exactly 12 cycles.
- **Mid-run stop:** `stop` sampled in cycle 6 (`q=1`) →
  - phase 0 deactivates entering `q=3`;
  - phase 1 deactivates entering `q=0` of the next period;
  - phases 2 and 3 never activate.
  - Confirm no phase level jumps by more than 1.
- **Reset mid-run:** assert `reset` at cycle 10 of RUN → next cycle all outputs equal reset values. A later `start` restarts from `q=0`.
- **Conflicts and invariant:**
  - `start` with `stop` in IDLE → stays IDLE.
  - `start` during DRAIN → ignored.
  - Throughout every scenario, `pos + neg == 4` for every phase.
